// File: rtl/meas_result_fifo.sv
// meas_result_fifo
//   Captures the summed measurement count at the end of each gate window,
//   once the count has settled, and buffers it in a first-word-fall-through
//   FIFO so the SPI readout can drain back-to-back results.
//
// Optional feature macro: MEAS_FIFO_SEQ_EN
//   defined   -> sequence counter and per-entry sequence storage are built,
//                seq_out carries the head entry's sequence number
//   undefined -> no sequence storage, seq_out is tied to 0
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high
//   sample_gate  gate window, asynchronous to clk
//   count_in     measurement count, stable once the gate has closed
//   pop          consume the head entry
//   clear_flags  clear the sticky overflow / missed flags
//   data_out     head entry count (valid while rd_valid)
//   seq_out      head entry sequence number (valid while rd_valid)
//   rd_valid     FIFO not empty
//   level        number of stored entries
//   overflow     sticky: a result was dropped because the FIFO was full
//   missed       sticky: a capture was aborted because the gate reopened
//   meas_busy    a measurement is in progress (gate open, settling, writing)
module meas_result_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int SEQ_W      = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_gate,
  input  logic [DATA_W-1:0]        count_in,
  input  logic                     pop,
  input  logic                     clear_flags,
  output logic [DATA_W-1:0]        data_out,
  output logic [SEQ_W-1:0]         seq_out,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     missed,
  output logic                     meas_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, GATE_OPEN, SETTLE, WRITE} state_t;

  state_t state, state_next;
  logic [3:0] settle_cnt, settle_cnt_next;
  logic       do_write, do_abort;

  // Gate synchronizer (p0, p1) plus a delayed copy (p2) for edge detection
  logic gate_p0, gate_p1, gate_p2;
  logic gate_rise, gate_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_p0 <= 1'b0;
      gate_p1 <= 1'b0;
      gate_p2 <= 1'b0;
    end else begin
      gate_p0 <= sample_gate;
      gate_p1 <= gate_p0;
      gate_p2 <= gate_p1;
    end
  end

  assign gate_rise = gate_p1 & ~gate_p2;
  assign gate_fall = ~gate_p1 & gate_p2;

  // Measurement FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    do_write        = 1'b0;
    do_abort        = 1'b0;
    case (state)
      IDLE: begin
        if (gate_rise) state_next = GATE_OPEN;
      end
      GATE_OPEN: begin
        if (gate_fall) begin
          state_next      = SETTLE;
          settle_cnt_next = 4'(SETTLE_CYC);
        end
      end
      SETTLE: begin
        // A reopened gate means count_in is moving again: abandon this window.
        if (gate_p1) begin
          state_next = IDLE;
          do_abort   = 1'b1;
        end else if (settle_cnt == 4'd1) begin
          state_next = WRITE;
        end else begin
          settle_cnt_next = settle_cnt - 4'd1;
        end
      end
      WRITE: begin
        do_write   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO pointers carry one extra wrap bit so full and empty are distinct
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_cnt, rd_cnt, wr_cnt_next, rd_cnt_next, fill;
  logic [AW-1:0]     rd_addr_next;
  logic              full, empty, pop_eff, push_eff, drop, bypass;

  assign fill     = wr_cnt - rd_cnt;
  assign full     = (fill == (AW+1)'(DEPTH));
  assign empty    = (fill == '0);
  assign pop_eff  = pop & ~empty;
  assign push_eff = do_write & (~full | pop_eff);
  assign drop     = do_write & full & ~pop_eff;

  assign wr_cnt_next  = push_eff ? wr_cnt + (AW+1)'(1) : wr_cnt;
  assign rd_cnt_next  = pop_eff  ? rd_cnt + (AW+1)'(1) : rd_cnt;
  assign rd_addr_next = rd_cnt_next[AW-1:0];
  // The entry being written becomes the head in the same edge when it lands
  // in the slot the read pointer is about to point at.
  assign bypass = push_eff && (wr_cnt[AW-1:0] == rd_addr_next);

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_cnt[AW-1:0]] <= count_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      level     <= '0;
      rd_valid  <= 1'b0;
      data_out  <= '0;
      overflow  <= 1'b0;
      missed    <= 1'b0;
      meas_busy <= 1'b0;
    end else begin
      wr_cnt    <= wr_cnt_next;
      rd_cnt    <= rd_cnt_next;
      level     <= wr_cnt_next - rd_cnt_next;
      rd_valid  <= (wr_cnt_next != rd_cnt_next);
      if (wr_cnt_next != rd_cnt_next)
        data_out <= bypass ? count_in : mem[rd_addr_next];
      overflow  <= drop     | (overflow & ~clear_flags);
      missed    <= do_abort | (missed   & ~clear_flags);
      meas_busy <= (state_next != IDLE);
    end
  end

`ifdef MEAS_FIFO_SEQ_EN
  logic [SEQ_W-1:0] seq_cnt;
  logic [SEQ_W-1:0] seq_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push_eff) seq_mem[wr_cnt[AW-1:0]] <= seq_cnt;
  end

  // Every finished or aborted measurement consumes a sequence number,
  // including ones dropped on overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_cnt <= '0;
      seq_out <= '0;
    end else begin
      if (do_write | do_abort) seq_cnt <= seq_cnt + SEQ_W'(1);
      if (wr_cnt_next != rd_cnt_next)
        seq_out <= bypass ? seq_cnt : seq_mem[rd_addr_next];
    end
  end
`else
  assign seq_out = '0;
`endif

endmodule
